// File: rtl/alu_pkg.sv
// Shared opcode, flag-index and FSM-state definitions for the ALU command issuer
// and its response FIFO.
package alu_pkg;

  localparam logic [3:0] OP_DIV  = 4'd0;
  localparam logic [3:0] OP_SRA  = 4'd1;
  localparam logic [3:0] OP_ROR  = 4'd2;
  localparam logic [3:0] OP_ROL  = 4'd3;
  localparam logic [3:0] OP_SGT  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_AND  = 4'd6;
  localparam logic [3:0] OP_MAX  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SGE  = 4'd9;
  localparam logic [3:0] OP_NAND = 4'd10;
  localparam logic [3:0] OP_SLL  = 4'd11;

  localparam int unsigned FLAG_W     = 4;
  localparam int unsigned FLAG_CARRY = 3;
  localparam int unsigned FLAG_ZERO  = 2;
  localparam int unsigned FLAG_OVF   = 1;
  localparam int unsigned FLAG_SIGN  = 0;

  typedef enum logic {
    ST_IDLE,
    ST_DRIVE
  } state_t;

endpackage

// File: rtl/alu_rsp_fifo.sv
// Synchronous response FIFO; head entry reads as zero while empty so the
// response outputs are clean after reset.
module alu_rsp_fifo #(
  parameter int unsigned W     = 25,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [W-1:0]               din,
  input  logic                       rd_en,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign do_push = wr_en && !full;
  assign do_pop  = rd_en && !empty;
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Sequential initiator for a combinational ALU: registers operands, captures the
// settled result one cycle later and queues tagged responses.
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int unsigned              WIDTH         = 16,
  parameter int unsigned              OPCODE_W      = 4,
  parameter int unsigned              SHIFT_W       = 5,
  parameter int unsigned              TAG_W         = 4,
  parameter int unsigned              RSP_DEPTH     = 4,
  parameter logic [(2**OPCODE_W)-1:0] OP_VALID_MASK = 16'h0CEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [OPCODE_W-1:0] cmd_opcode,
  input  logic [WIDTH-1:0]    cmd_a,
  input  logic [WIDTH-1:0]    cmd_b,
  input  logic [SHIFT_W-1:0]  cmd_shift,
  input  logic [TAG_W-1:0]    cmd_tag,
  output logic [OPCODE_W-1:0] alu_opcode,
  output logic [WIDTH-1:0]    alu_input1,
  output logic [WIDTH-1:0]    alu_input2,
  output logic [SHIFT_W-1:0]  alu_shiftValue,
  input  logic [WIDTH-1:0]    alu_result,
  input  logic [3:0]          alu_flags,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [WIDTH-1:0]    rsp_result,
  output logic [3:0]          rsp_flags,
  output logic                rsp_err,
  output logic [TAG_W-1:0]    rsp_tag,
  output logic [3:0]          sticky_flags,
  input  logic                sticky_clr,
  output logic                busy
);

  localparam int unsigned DW = WIDTH + FLAG_W + 1 + TAG_W;
  localparam int unsigned CW = $clog2(RSP_DEPTH) + 1;

  state_t         state;
  state_t         state_nx;
  logic [TAG_W-1:0] tag_q;
  logic           err_q;
  logic           accept;
  logic           legal;
  logic           push;
  logic           legal_push;
  logic [DW-1:0]  push_data;
  logic [DW-1:0]  head_data;
  logic           fifo_full;
  logic           fifo_empty;
  logic [CW-1:0]  fifo_count;

  assign legal      = OP_VALID_MASK[cmd_opcode];
  assign accept     = cmd_valid && cmd_ready;
  assign push       = (state == ST_DRIVE);
  assign legal_push = push && !err_q;
  assign busy       = (state != ST_IDLE);
  assign push_data  = err_q ? {{WIDTH{1'b0}}, {FLAG_W{1'b0}}, 1'b1, tag_q}
                            : {alu_result, alu_flags, 1'b0, tag_q};

  always_comb begin
    state_nx  = state;
    cmd_ready = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_ready = !fifo_full;
        if (cmd_valid && !fifo_full) state_nx = ST_DRIVE;
      end
      ST_DRIVE: state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Illegal opcodes leave the ALU drive registers untouched so the ALU keeps
  // presenting the last legal command.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_opcode     <= '0;
      alu_input1     <= '0;
      alu_input2     <= '0;
      alu_shiftValue <= '0;
      tag_q          <= '0;
      err_q          <= 1'b0;
      sticky_flags   <= '0;
    end else begin
      if (accept) begin
        tag_q <= cmd_tag;
        err_q <= !legal;
        if (legal) begin
          alu_opcode     <= cmd_opcode;
          alu_input1     <= cmd_a;
          alu_input2     <= cmd_b;
          alu_shiftValue <= cmd_shift;
        end
      end
      sticky_flags <= (sticky_clr ? 4'b0000 : sticky_flags)
                    | (legal_push ? alu_flags : 4'b0000);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      assert (fifo_count != CW'(RSP_DEPTH));
    end
  end

  alu_rsp_fifo #(
    .W     (DW),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr_en (push),
    .din   (push_data),
    .rd_en (rsp_ready),
    .dout  (head_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign rsp_valid = !fifo_empty;
  assign {rsp_result, rsp_flags, rsp_err, rsp_tag} = head_data;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer with a behavioural 16-bit ALU on the alu_* ports
// and a queue-based response scoreboard.
module tb_alu_cmd_issuer;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_opcode;
  logic [15:0] cmd_a;
  logic [15:0] cmd_b;
  logic [4:0]  cmd_shift;
  logic [3:0]  cmd_tag;
  logic [3:0]  alu_opcode;
  logic [15:0] alu_input1;
  logic [15:0] alu_input2;
  logic [4:0]  alu_shiftValue;
  logic [15:0] alu_result;
  logic [3:0]  alu_flags;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic [3:0]  rsp_flags;
  logic        rsp_err;
  logic [3:0]  rsp_tag;
  logic [3:0]  sticky_flags;
  logic        sticky_clr;
  logic        busy;

  typedef struct {
    logic [15:0] res;
    logic [3:0]  flg;
    logic        err;
    logic [3:0]  tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  alu_cmd_issuer #(
    .WIDTH         (16),
    .OPCODE_W      (4),
    .SHIFT_W       (5),
    .TAG_W         (4),
    .RSP_DEPTH     (4),
    .OP_VALID_MASK (16'h0CEF)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_opcode     (cmd_opcode),
    .cmd_a          (cmd_a),
    .cmd_b          (cmd_b),
    .cmd_shift      (cmd_shift),
    .cmd_tag        (cmd_tag),
    .alu_opcode     (alu_opcode),
    .alu_input1     (alu_input1),
    .alu_input2     (alu_input2),
    .alu_shiftValue (alu_shiftValue),
    .alu_result     (alu_result),
    .alu_flags      (alu_flags),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_result     (rsp_result),
    .rsp_flags      (rsp_flags),
    .rsp_err        (rsp_err),
    .rsp_tag        (rsp_tag),
    .sticky_flags   (sticky_flags),
    .sticky_clr     (sticky_clr),
    .busy           (busy)
  );

  // Behavioural ALU: carry/overflow never set; zero and sign from the result.
  logic [15:0] r;
  logic [31:0] rot;
  always_comb begin
    r   = '0;
    rot = {alu_input1, alu_input1};
    case (alu_opcode)
      OP_DIV:  r = (alu_input2 == 16'h0) ? 16'h0 : alu_input1 / alu_input2;
      OP_SRA:  r = $signed(alu_input1) >>> alu_shiftValue;
      OP_ROR:  begin rot = {alu_input1, alu_input1} >> alu_shiftValue[3:0]; r = rot[15:0];  end
      OP_ROL:  begin rot = {alu_input1, alu_input1} << alu_shiftValue[3:0]; r = rot[31:16]; end
      OP_SGT:  r = {15'h0, $signed(alu_input1) > $signed(alu_input2)};
      OP_OR:   r = alu_input1 | alu_input2;
      OP_AND:  r = alu_input1 & alu_input2;
      OP_MAX:  r = (alu_input1 > alu_input2) ? alu_input1 : alu_input2;
      OP_SLT:  r = {15'h0, $signed(alu_input1) < $signed(alu_input2)};
      OP_SGE:  r = {15'h0, $signed(alu_input1) >= $signed(alu_input2)};
      OP_NAND: r = ~(alu_input1 & alu_input2);
      OP_SLL:  r = alu_input1 << alu_shiftValue;
      default: r = '0;
    endcase
    alu_result = r;
    alu_flags  = {1'b0, (r == 16'h0), 1'b0, r[15]};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: sample at negedge, the DUT pops on the following posedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_rsp: got tag %0h result %0h, expected no response", rsp_tag, rsp_result);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_result", 32'(rsp_result), 32'(e.res));
          chk("rsp_flags",  32'(rsp_flags),  32'(e.flg));
          chk("rsp_err",    32'(rsp_err),    32'(e.err));
          chk("rsp_tag",    32'(rsp_tag),    32'(e.tag));
        end
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [4:0] sh, input logic [3:0] tg, input logic exp_rsp,
                       input logic [15:0] er, input logic [3:0] ef, input logic ee);
    int unsigned waited = 0;
    bit done = 0;
    exp_t e;
    cmd_opcode = op; cmd_a = a; cmd_b = b; cmd_shift = sh; cmd_tag = tg;
    cmd_valid  = 1'b1;
    while (!done && waited < 50) begin
      @(negedge clk);
      if (cmd_ready === 1'b1) begin
        @(posedge clk);
        done = 1;
      end else begin
        waited++;
      end
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: tag %0h not accepted within %0d cycles", tg, waited);
      @(posedge clk);
    end else if (exp_rsp) begin
      e.res = er; e.flg = ef; e.err = ee; e.tag = tg;
      exp_q.push_back(e);
    end
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int unsigned n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1 chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_opcode = '0; cmd_a = '0; cmd_b = '0;
    cmd_shift = '0; cmd_tag = '0; rsp_ready = 1'b1; sticky_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("reset_rsp_valid", 32'(rsp_valid),    32'd0);
    chk("reset_busy",      32'(busy),         32'd0);
    chk("reset_alu_op",    32'(alu_opcode),   32'd0);
    chk("reset_alu_in1",   32'(alu_input1),   32'd0);
    chk("reset_sticky",    32'(sticky_flags), 32'd0);
    chk("reset_rsp_res",   32'(rsp_result),   32'd0);
    chk("reset_cmd_ready", 32'(cmd_ready),    32'd1);

    // AND with latency check
    issue(OP_AND, 16'hF0F0, 16'h0FF0, 5'd0, 4'd3, 1'b1, 16'h00F0, 4'b0000, 1'b0);
    chk("and_busy",        32'(busy),       32'd1);
    chk("and_alu_in1",     32'(alu_input1), 32'hF0F0);
    chk("and_valid_early", 32'(rsp_valid),  32'd0);
    @(posedge clk); #1;
    chk("and_valid_lat",   32'(rsp_valid),  32'd1);

    // DIV by zero sets sticky zero
    issue(OP_DIV, 16'h0064, 16'h0000, 5'd0, 4'd1, 1'b1, 16'h0000, 4'b0100, 1'b0);
    @(posedge clk); #1;
    chk("div_sticky", 32'(sticky_flags), 32'h4);

    // Illegal opcode 13
    issue(4'd13, 16'h1234, 16'h5678, 5'd9, 4'd7, 1'b1, 16'h0000, 4'b0000, 1'b1);
    @(posedge clk); #1;
    chk("ill_alu_op",  32'(alu_opcode),     32'(OP_DIV));
    chk("ill_alu_in1", 32'(alu_input1),     32'h0064);
    chk("ill_alu_in2", 32'(alu_input2),     32'h0000);
    chk("ill_alu_sh",  32'(alu_shiftValue), 32'd0);
    chk("ill_sticky",  32'(sticky_flags),   32'h4);
    wait_drain();

    // Backpressure: four queued, fifth held until the consumer resumes
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      issue(OP_SLL, 16'h0001, 16'h0000, 5'(i), 4'(8 + i), 1'b1, 16'h0001 << i, 4'b0000, 1'b0);
    fork
      issue(OP_SLL, 16'h0001, 16'h0000, 5'd4, 4'd12, 1'b1, 16'h0010, 4'b0000, 1'b0);
      begin
        repeat (3) @(posedge clk);
        #1;
        chk("full_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("full_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("full_head_res",  32'(rsp_result), 32'h0001);
        rsp_ready = 1'b1;
      end
    join
    wait_drain();

    // Clear and capture on the same edge keep the new flags
    issue(OP_SRA, 16'h8000, 16'h0000, 5'd4, 4'd2, 1'b1, 16'hF800, 4'b0001, 1'b0);
    sticky_clr = 1'b1;
    @(posedge clk); #1 sticky_clr = 1'b0;
    chk("sra_sticky", 32'(sticky_flags), 32'h1);
    sticky_clr = 1'b1;
    @(posedge clk); #1 sticky_clr = 1'b0;
    chk("clr_sticky", 32'(sticky_flags), 32'h0);
    wait_drain();

    // Reset while in DRIVE drops the command
    issue(OP_OR, 16'h0001, 16'h0002, 5'd3, 4'd5, 1'b0, 16'h0000, 4'b0000, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("rstd_rsp_valid", 32'(rsp_valid),      32'd0);
    chk("rstd_busy",      32'(busy),           32'd0);
    chk("rstd_alu_op",    32'(alu_opcode),     32'd0);
    chk("rstd_alu_in1",   32'(alu_input1),     32'd0);
    chk("rstd_alu_in2",   32'(alu_input2),     32'd0);
    chk("rstd_alu_sh",    32'(alu_shiftValue), 32'd0);
    repeat (4) @(posedge clk);
    #1 chk("rstd_no_rsp", 32'(rsp_valid), 32'd0);

    issue(OP_MAX, 16'h0005, 16'h0009, 5'd0, 4'd6, 1'b1, 16'h0009, 4'b0000, 1'b0);
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
